// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one ALU between the execute stage (requester 0) and the branch unit (requester 1).
// Build option ALU_ARB_FIXED_PRIO_EN: requester 0 always wins ties (default is round-robin).
package mypkg;
    typedef enum logic [3:0] {
        A_ADD  = 4'd0,
        A_SUB  = 4'd1,
        A_XOR  = 4'd2,
        A_OR   = 4'd3,
        A_AND  = 4'd4,
        A_SLL  = 4'd5,
        A_SRL  = 4'd6,
        A_SRA  = 4'd7,
        A_SLT  = 4'd8,
        A_SLTU = 4'd9
    } alu_op_e;
endpackage

module alu_share_arb #(
    parameter int XLEN = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [1:0]         req_valid_i,
    output logic [1:0]         req_ready_o,
    input  mypkg::alu_op_e     req_op_i [2],
    input  logic [XLEN-1:0]    req_a_i [2],
    input  logic [XLEN-1:0]    req_b_i [2],
    output logic [1:0]         rsp_valid_o,
    input  logic [1:0]         rsp_ready_i,
    output logic [XLEN-1:0]    rsp_data_o,
    output logic               rsp_flag_o,
    output logic               rsp_err_o,
    output logic [XLEN-1:0]    alu_a_o,
    output logic [XLEN-1:0]    alu_b_o,
    output mypkg::alu_op_e     alu_op_o,
    input  logic [XLEN-1:0]    alu_data_i,
    input  logic               alu_flag_i
);
    import mypkg::*;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            gnt_q, gnt_d;
    logic [XLEN-1:0] alu_a_q, alu_a_d;
    logic [XLEN-1:0] alu_b_q, alu_b_d;
    alu_op_e         alu_op_q, alu_op_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic            rsp_flag_q, rsp_flag_d;
    logic            rsp_err_q, rsp_err_d;
    logic            win;
    logic            req_hs;
    logic            op_legal;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic            last_q, last_d;
`endif

    // Tie-break: round-robin against the last grantee, or fixed to requester 0.
    always_comb begin
        win = 1'b0;
        if (req_valid_i == 2'b10) begin
            win = 1'b1;
        end else if (req_valid_i == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            win = 1'b0;
`else
            win = ~last_q;
`endif
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign req_ready_o[gi] = (state_q == ST_IDLE) && !rst_i && req_valid_i[gi] && (win == 1'(gi));
        assign rsp_valid_o[gi] = (state_q == ST_RESP) && (gnt_q == 1'(gi));
    end

    assign req_hs = |(req_valid_i & req_ready_o);

    always_comb begin
        case (alu_op_q)
            A_ADD, A_SUB, A_XOR, A_OR, A_AND,
            A_SLL, A_SRL, A_SRA, A_SLT, A_SLTU: op_legal = 1'b1;
            default:                            op_legal = 1'b0;
        endcase
    end

    // Operand registers change only on acceptance, so the ALU inputs are quiet outside EXEC.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        rsp_data_d = rsp_data_q;
        rsp_flag_d = rsp_flag_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_hs) begin
                    gnt_d    = win;
                    alu_a_d  = req_a_i[win];
                    alu_b_d  = req_b_i[win];
                    alu_op_d = req_op_i[win];
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d = op_legal ? alu_data_i : '0;
                rsp_flag_d = op_legal ? alu_flag_i : 1'b0;
                rsp_err_d  = ~op_legal;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i[gnt_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        last_d = last_q;
        if (req_hs) begin
            last_d = win;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= A_ADD;
            rsp_data_q <= '0;
            rsp_flag_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            rsp_data_q <= rsp_data_d;
            rsp_flag_q <= rsp_flag_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign alu_a_o    = alu_a_q;
    assign alu_b_o    = alu_b_q;
    assign alu_op_o   = alu_op_q;
    assign rsp_data_o = rsp_data_q;
    assign rsp_flag_o = rsp_flag_q;
    assign rsp_err_o  = rsp_err_q;

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Sequencing controller that shares the single `alu` instance between two requesters: requester 0 (execute stage) and requester 1 (branch-compare unit). It accepts one operation at a time over a valid/ready handshake and arbitrates round-robin between the two requesters. It registers the operands and opcode, drives them to the ALU for one execute cycle, and captures `alu_data_o` and `bru_exp_o`. It then holds the result for the granted requester until that requester accepts it.

## Interface
- `XLEN`, 32, operand/result width; must match the ALU datapath.
- `clk_i  in  1  clock`; all state updates on rising edge.
- `rst_i  in  1  reset`; synchronous, active-high.
- `req_valid_i  in  2  per-requester request valid; bit n = requester n.`
- `req_ready_o  out  2  per-requester request accept.`
- `req_op_i  in  2 x alu_op_e  per-requester opcode (mypkg).`
- `req_a_i  in  2 x XLEN  per-requester operand A.`
- `req_b_i  in  2 x XLEN  per-requester operand B.`
- `rsp_valid_o  out  2  per-requester result valid; at most one bit set.`
- `rsp_ready_i  in  2  per-requester result accept.`
- `rsp_data_o  out  XLEN  result data; shared by both requesters, qualified by rsp_valid_o.`
- `rsp_flag_o  out  1  captured bru_exp_o (result non-zero).`
- `rsp_err_o  out  1  opcode was not a defined alu_op_e member.`
- `alu_a_o / alu_b_o  out  XLEN  to ALU operand_a_i / operand_b_i.`
- `alu_op_o  out  alu_op_e  to ALU alu_op_i.`
- `alu_data_i  in  XLEN  from ALU alu_data_o.`
- `alu_flag_i  in  1  from ALU bru_exp_o.`

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - `req_ready_o` is combinational: the winner bit is 1 when its `req_valid_i` is 1; all other bits are 0.
  - On a handshake, latch op/a/b, record the grantee in `gnt_q`, set `last_q` = grantee, and go to EXEC.
- **Arbitration:**
  - If one requester is valid, it wins.
  - If both are valid, the requester != `last_q` wins.
  - `last_q` resets to 1, so requester 0 wins the first tie.
- **EXEC:**
  - `alu_a_o`/`alu_b_o`/`alu_op_o` are driven from the latched registers; they are stable for the whole cycle.
  - At the end of the cycle, capture `alu_data_i`→`rsp_data_o` and `alu_flag_i`→`rsp_flag_o`, then go to RESP.
  - For an undefined opcode, capture data=0, flag=0, err=1 instead of the ALU output.
- **RESP:**
  - `rsp_valid_o[gnt_q]`=1; `rsp_data_o`/`rsp_flag_o`/`rsp_err_o` are held stable.
  - On `rsp_ready_i[gnt_q]`=1, go to IDLE.
  - `rsp_ready_i` of the non-granted requester is ignored.
- **Outside EXEC:** ALU outputs keep their last driven values, so the ALU latch does not toggle.
- **Requester stability:** a requester must hold valid/op/a/b stable until accepted. The block samples them only on the handshake cycle.

## Timing
- **Reset values:** all outputs 0, `alu_op_o`=A_ADD, state IDLE, `last_q`=1, `gnt_q`=0.
- **Latency:** handshake at cycle N → ALU operands valid in cycle N+1 → `rsp_valid_o` high in cycle N+2.
- **Throughput:** the minimum is one operation per 3 cycles when `rsp_ready_i` is held high.
- No request is accepted in EXEC or RESP; `req_ready_o`=0 in both states.
- **Response back-pressure:** RESP holds indefinitely; the data does not change while waiting.
- **Simultaneous events:**
  - A response handshake in RESP returns to IDLE. A new request is accepted in the following cycle, not the same cycle.
  - Both requests valid in IDLE → exactly one `req_ready_o` bit is high.
- **Valid drop before accept:** a requester that drops valid before it is accepted leaves no state.
- **Reset mid-operation:** `rst_i` in EXEC or RESP discards the operation. The next cycle is IDLE with all outputs at reset values and no `rsp_valid_o`.
- **Arithmetic:** the block performs no arithmetic. All result bits come from the ALU as-is, width XLEN.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`:
  - Defined: requester 0 always wins a tie; `last_q` is not used (branch unit may starve).
  - Undefined (default): round-robin as described above.

## Test plan
- Reset, then only req0 sends A_ADD a=5 b=7 → `req_ready_o`=01 in cycle 0, `alu_*` = 5/7/A_ADD in cycle 1, `rsp_valid_o`=01 with data 12 and flag 1 in cycle 2.
- Both requests valid every cycle, `rsp_ready_i`=11, req0 A_SUB 9,9 and req1 A_XOR 3,5 → grants alternate 0,1,0,1:
  - req0 result: data 0, flag 0.
  - req1 result: data 6, flag 1.
  - With `ALU_ARB_FIXED_PRIO_EN`, every grant goes to requester 0.
- req1 A_SLL a=1 b=4, `rsp_ready_i[1]` held low 5 cycles → `rsp_valid_o`=10 with data 16 held stable for 5 cycles; `req_ready_o`=00 throughout, even with req0 valid.
- Undefined opcode value from req0 → `rsp_err_o`=1, data 0, flag 0.
- `rst_i` pulsed in EXEC and, in a separate run, in RESP → next cycle all outputs 0, state IDLE; the next tie goes to requester 0.
- `rsp_ready_i[0]`=1 while granted to requester 1 → no completion; completion happens only on `rsp_ready_i[1]`.
